fft_result_capture: RTL and testbench
=====================================

Name: fft_result_capture

Overview:
- Sink for one N-point FFT frame at the output end of the FFT datapath.
- Accepts complex bins over a valid/ready stream, in bit-reversed order from the in-place butterfly stages. Stores them in natural order.
- Tracks the bin with the largest |re|+|im|.
- Replays the frame in natural order (bin 0..N-1) over a second valid/ready stream to the host/UART side. It is the consumer counterpart of the sample/twiddle ROMs that feed the FFT.

Parameters:
- DATA_W, 16, width of each signed real/imag component (two's complement)
- N, 8, bins per frame (power of 2, >=2)
- ADDR_W, 3, log2(N)
- BIT_REV, 1, 1: input bin k is written to address bitrev(k); 0: written to address k

Ports:
- clk  input  1  system clock, all logic rising-edge
- reset  input  1  synchronous, active-high
- start  input  1  pulse: arm capture of one frame
- in_valid  input  1  input bin valid
- in_ready  output  1  block can accept an input bin
- in_re  input  DATA_W  real part of bin
- in_im  input  DATA_W  imag part of bin
- out_valid  output  1  output bin valid
- out_ready  input  1  downstream accepts output bin
- out_re  output  DATA_W  real part, natural-order bin
- out_im  output  DATA_W  imag part
- out_idx  output  ADDR_W  bin index of out_re/out_im
- out_last  output  1  high with bin N-1
- peak_idx  output  ADDR_W  natural-order index of max |re|+|im|, valid when done=1
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse on acceptance of last output bin

Behaviour:
- Reset (synchronous, active-high, applied at clk edge):
  - State goes to IDLE.
  - Counters wr_cnt and rd_cnt go to 0; peak_idx=0; peak_val=0.
  - All outputs 0, including in_ready, out_valid, out_idx, out_last, busy, done.
  - Storage array contents are don't-care.
  - Reset mid-frame aborts the frame; no done pulse.
- States:
  - IDLE: in_ready=0, out_valid=0. start=1 -> FILL; wr_cnt=0, peak_val=0, peak_idx=0.
  - FILL: in_ready=1. On in_valid&in_ready: mem[wa]<={in_re,in_im} with wa=BIT_REV?bitrev(wr_cnt):wr_cnt; wr_cnt++. Accepting the bin with wr_cnt=N-1 -> DRAIN, rd_cnt=0.
  - DRAIN: in_ready=0, out_valid=1. out_re/out_im=mem[rd_cnt] (combinational read of register array); out_idx=rd_cnt; out_last=(rd_cnt==N-1). On out_valid&out_ready: rd_cnt++. Acceptance at rd_cnt=N-1 -> IDLE with done=1 for that cycle.
- Handshake rules:
  - Transfer occurs only when valid&ready at a clk edge.
  - out_re/out_im/out_idx/out_last are stable while out_valid&!out_ready.
  - in_ready does not depend combinationally on in_valid.
- Latency: the first output bin is valid the cycle after the last input bin is accepted. Best-case frame time is 2N+1 cycles from start.
- start is ignored outside IDLE. start and reset in the same cycle: reset wins.
- Peak tracking, per accepted input bin:
  - mag = |in_re|+|in_im|, computed in DATA_W+1 bits unsigned.
  - |-2^(DATA_W-1)| = 2^(DATA_W-1), with no wrap.
  - If mag > peak_val (strictly greater): peak_val<=mag, peak_idx<=wa.
  - Ties keep the earlier-accepted bin. First bin always loads when its mag>0. An all-zero frame gives peak_idx=0.
  - peak_idx holds until the next start.
- in_valid outside FILL is ignored (no write, no stall).

Decomposition:
- Shared package fft_pkg holds: DATA_W, N, ADDR_W constants; capture state encoding (IDLE=2'd0, FILL=2'd1, DRAIN=2'd2); bitrev function of ADDR_W bits. This package is also used by the FFT address generator.
- One natural sub-module: fft_abs_sum. It is combinational and computes |re|+|im| to DATA_W+1 bits. Everything else stays in this module.

Test Plan:
- Bit-reverse order, N=8, BIT_REV=1, out_ready=1: start, then input bins with in_re=k, in_im=-k for k=0..7. Output must be idx 0..7 with out_re=0,4,2,6,1,5,3,7. out_last only on idx 7. done pulses once. peak_idx=7 (mag 14 from input k=7).
- Cosine frame: input bins in bit-reversed slot order with X[1]=(508,0), X[7]=(508,0), all others 0 -> out bins 1 and 7 = 508 (0x01FC), others 0. peak_idx=1 (tie at 7 keeps first accepted).
- Backpressure: in DRAIN hold out_ready=0 for 5 cycles at rd_cnt=3 -> out_idx stays 3 with data unchanged. Then out_ready=1 -> remaining bins follow one per cycle.
- Input gaps and extreme value: in_valid toggling 1/0 in FILL, with in_re=0x8000, in_im=0x8000 on one bin -> exactly 8 bins written, no extras. That bin's mag=65536 is selected as peak.
- Protocol abuse: start pulsed during FILL and DRAIN, in_valid=1 in IDLE/DRAIN -> no state change and no writes. Frame output is identical to the clean run.
- Reset mid-operation: assert reset after 4 accepted inputs, then after 3 drained outputs -> next cycle state IDLE with all outputs 0 and no done pulse. A following full frame completes correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, result-capture state encoding and
// the bit-reversal helper used by both the address generator and the
// result-capture sink.
package fft_pkg;

  localparam int DATA_W = 16;
  localparam int N      = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } cap_state_t;

  // Mirror the ADDR_W-bit index: bit i moves to bit ADDR_W-1-i.
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_abs_sum.sv
// Combinational L1 magnitude |re|+|im| of a complex sample.
// Ports:
//   re, im : signed two's-complement components, DATA_W bits
//   mag    : unsigned |re|+|im|, DATA_W+1 bits (cannot overflow)
module fft_abs_sum #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  output logic        [DATA_W:0]   mag
);

  // Unsigned magnitude in DATA_W bits. The most negative input maps to
  // 2^(DATA_W-1), which is representable once the result is read unsigned.
  function automatic logic [DATA_W-1:0] abs_u(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] u;
    u = v;
    return u[DATA_W-1] ? (~u + DATA_W'(1)) : u;
  endfunction

  assign mag = {1'b0, abs_u(re)} + {1'b0, abs_u(im)};

endmodule

// File: rtl/fft_result_capture.sv
// FFT output sink. Captures one N-bin frame arriving on a valid/ready stream
// (bit-reversed order when BIT_REV=1), stores it in natural order, tracks the
// bin with the largest |re|+|im| and replays the frame bin 0..N-1 on a second
// valid/ready stream.
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   start                : arm capture of one frame (honoured only when idle)
//   in_valid/in_ready    : input bin handshake, data on in_re/in_im
//   out_valid/out_ready  : output bin handshake, data on out_re/out_im
//   out_idx, out_last    : natural-order bin index, high with bin N-1
//   peak_idx             : natural-order index of max |re|+|im|
//   busy                 : capture or replay in progress
//   done                 : one-cycle pulse after the last bin is accepted
module fft_result_capture #(
  parameter int DATA_W  = 16,
  parameter int N       = 8,
  parameter int ADDR_W  = 3,
  parameter int BIT_REV = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic        [ADDR_W-1:0] out_idx,
  output logic                     out_last,
  output logic        [ADDR_W-1:0] peak_idx,
  output logic                     busy,
  output logic                     done
);
  import fft_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  cap_state_t                state;
  logic        [ADDR_W-1:0]  wr_cnt;
  logic        [ADDR_W-1:0]  rd_cnt;
  logic        [ADDR_W-1:0]  wa;
  logic        [DATA_W:0]    mag;
  logic        [DATA_W:0]    peak_val;
  logic                      in_fire;
  logic                      out_fire;
  logic signed [DATA_W-1:0]  mem_re [N];
  logic signed [DATA_W-1:0]  mem_im [N];

  assign wa = (BIT_REV != 0) ? bitrev(wr_cnt) : wr_cnt;

  fft_abs_sum #(.DATA_W(DATA_W)) u_abs (
    .re  (in_re),
    .im  (in_im),
    .mag (mag)
  );

  // Handshake signals decode only the registered state, so in_ready never
  // depends on in_valid and the output stream is stable under backpressure.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != IDLE);

  assign out_idx  = rd_cnt;
  assign out_last = out_valid && (rd_cnt == LAST);
  assign out_re   = out_valid ? mem_re[rd_cnt] : '0;
  assign out_im   = out_valid ? mem_im[rd_cnt] : '0;

  // Frame storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[wa] <= in_re;
      mem_im[wa] <= in_im;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      peak_val <= '0;
      peak_idx <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            wr_cnt   <= '0;
            peak_val <= '0;
            peak_idx <= '0;
          end
        end
        FILL: begin
          if (in_fire) begin
            wr_cnt <= wr_cnt + 1'b1;
            // Strict compare: ties keep the earlier-accepted bin.
            if (mag > peak_val) begin
              peak_val <= mag;
              peak_idx <= wa;
            end
            if (wr_cnt == LAST) begin
              state  <= DRAIN;
              rd_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_result_capture.sv
module tb_fft_result_capture;

  localparam int DW = 16;
  localparam int NB = 8;
  localparam int AW = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic        [AW-1:0] out_idx;
  logic                 out_last;
  logic        [AW-1:0] peak_idx;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  fft_result_capture #(.DATA_W(DW), .N(NB), .ADDR_W(AW), .BIT_REV(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .peak_idx  (peak_idx),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [AW-1:0]        idx;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 last;
  } exp_t;

  exp_t                 sb[$];
  int                   total = 0;
  int                   bad = 0;
  logic                 exp_done = 1'b0;
  int                   out_cnt = 0;
  int                   bp_mode = 0;
  int                   hold = 0;
  int                   exp_peak = 0;
  logic signed [DW-1:0] fr_re[NB];
  logic signed [DW-1:0] fr_im[NB];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < AW; i++)
      if ((k >> i) & 1) r |= 1 << (AW - 1 - i);
    return r;
  endfunction

  function automatic int absv(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference model: input k lands at natural slot brev(k); the replay of
  // slot i therefore carries input brev(i). Peak scans in acceptance order.
  task automatic build_expect();
    exp_t e;
    int best = 0;
    int m;
    for (int i = 0; i < NB; i++) begin
      e.idx  = AW'(i);
      e.re   = fr_re[brev(i)];
      e.im   = fr_im[brev(i)];
      e.last = (i == NB - 1);
      sb.push_back(e);
    end
    exp_peak = 0;
    for (int k = 0; k < NB; k++) begin
      m = absv(int'(fr_re[k])) + absv(int'(fr_im[k]));
      if (m > best) begin
        best = m;
        exp_peak = brev(k);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("reset_state",
        64'({busy, in_ready, out_valid, out_last, done, out_idx, peak_idx, out_re, out_im}),
        64'(0));
    reset = 1'b0;
    sb.delete();
    exp_done = 1'b0;
    out_cnt = 0;
  endtask

  task automatic run_frame(input int gaps, input int abuse, input int abort_in, input int abort_out);
    int   guard;
    logic fire;
    hold = 0;
    out_cnt = 0;
    if (abuse != 0) begin
      repeat (3) begin
        in_valid = 1'b1;
        in_re = DW'($urandom);
        in_im = DW'($urandom);
        tick();
      end
      chk("idle_ignores_in_valid", 64'({busy, in_ready}), 64'(0));
    end
    build_expect();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 64'({busy, in_ready}), 64'(2'b11));
    for (int k = 0; k < NB; k++) begin
      if (k == abort_in) begin
        do_reset();
        return;
      end
      guard = 0;
      forever begin
        in_valid = (gaps != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        in_re = in_valid ? fr_re[k] : DW'($urandom);
        in_im = in_valid ? fr_im[k] : DW'($urandom);
        start = (abuse != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        fire = in_valid && in_ready;
        tick();
        if (fire) break;
        guard++;
        if (guard > 50) begin
          bad++;
          $display("FAIL in_ready_timeout: bin %0d never accepted", k);
          $fatal(1, "input stalled");
        end
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("first_out_latency", 64'({out_valid, in_ready, out_idx}), 64'({1'b1, 1'b0, 3'd0}));
    guard = 0;
    while (busy) begin
      if (abort_out >= 0 && out_cnt >= abort_out) begin
        do_reset();
        return;
      end
      in_valid = (abuse != 0) ? 1'b1 : 1'b0;
      in_re = DW'($urandom);
      in_im = DW'($urandom);
      start = (abuse != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      guard++;
      if (guard > 300) begin
        bad++;
        $display("FAIL drain_timeout: frame never completed");
        $fatal(1, "drain stalled");
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("peak_idx", 64'(peak_idx), 64'(exp_peak));
    chk("all_bins_seen", 64'(sb.size()), 64'(0));
  endtask

  // Output monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("done", 64'(done), 64'(exp_done));
        exp_done = 1'b0;
        if (out_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: idx %0d re %0d im %0d with nothing expected", out_idx, out_re, out_im);
          end else begin
            e = sb[0];
            chk($sformatf("out_bin%0d", e.idx),
                64'({out_idx, out_re, out_im, out_last}),
                64'({e.idx, e.re, e.im, e.last}));
            if (out_ready) begin
              void'(sb.pop_front());
              out_cnt++;
              if (e.last) exp_done = 1'b1;
            end
          end
        end
      end
    end
  end

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && out_idx == 3 && hold < 5) begin
            out_ready = 1'b0;
            hold++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin
    do_reset();
    tick();

    // Ramp in bit-reversed order.
    for (int k = 0; k < NB; k++) begin
      fr_re[k] = DW'(k);
      fr_im[k] = DW'(-k);
    end
    bp_mode = 0;
    run_frame(0, 0, -1, -1);

    // Cosine: X[1] and X[7] arrive at acceptance slots 4 and 7.
    for (int k = 0; k < NB; k++) begin
      fr_re[k] = '0;
      fr_im[k] = '0;
    end
    fr_re[4] = 16'sd508;
    fr_re[7] = 16'sd508;
    run_frame(0, 0, -1, -1);

    // Backpressure held at bin 3.
    for (int k = 0; k < NB; k++) begin
      fr_re[k] = DW'($urandom);
      fr_im[k] = DW'($urandom);
    end
    bp_mode = 2;
    run_frame(0, 0, -1, -1);
    bp_mode = 0;

    // Input gaps with the most negative value on one bin.
    for (int k = 0; k < NB; k++) begin
      fr_re[k] = DW'($urandom_range(0, 2000) - 1000);
      fr_im[k] = DW'($urandom_range(0, 2000) - 1000);
    end
    fr_re[5] = 16'sh8000;
    fr_im[5] = 16'sh8000;
    run_frame(1, 0, -1, -1);

    // Protocol abuse on the ramp frame.
    for (int k = 0; k < NB; k++) begin
      fr_re[k] = DW'(k);
      fr_im[k] = DW'(-k);
    end
    run_frame(0, 1, -1, -1);

    // Reset mid-fill, mid-drain, then a clean frame.
    for (int k = 0; k < NB; k++) begin
      fr_re[k] = DW'($urandom);
      fr_im[k] = DW'($urandom);
    end
    run_frame(0, 0, 4, -1);
    tick();
    run_frame(0, 0, -1, 3);
    tick();
    run_frame(0, 0, -1, -1);

    // Random frames with random gaps and backpressure.
    bp_mode = 1;
    repeat (6) begin
      for (int k = 0; k < NB; k++) begin
        fr_re[k] = DW'($urandom);
        fr_im[k] = DW'($urandom);
      end
      run_frame(1, 0, -1, -1);
      tick();
    end
    bp_mode = 0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
